// File: rtl/spi_reg_seq.sv
// Register-access sequencer: turns one read/write request into a command word
// and a data word on an attached spi_master, then returns a response.
module spi_reg_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [DATA_WIDTH-2:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  spi_go,
    output logic [DATA_WIDTH-1:0] spi_datai,
    input  logic [DATA_WIDTH-1:0] spi_datao,
    input  logic                  spi_busy,
    input  logic                  spi_done
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        CMD_GO,
        CMD_WAIT,
        GAP,
        DATA_GO,
        DATA_WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic                    rw_q;
    logic [DATA_WIDTH-2:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [TW-1:0]           timer;
    logic [GW-1:0]           gap_cnt;
    logic                    seen_busy;
    logic                    complete;

    // A done pulse only counts once the master has been seen busy for this word.
    assign complete = seen_busy && !spi_busy && spi_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            spi_go    <= 1'b0;
            spi_datai <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            seen_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rw_q      <= req_rw;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        spi_go    <= 1'b1;
                        spi_datai <= {req_rw, req_addr};
                        state     <= CMD_GO;
                    end
                end
                CMD_GO: begin
                    spi_go    <= 1'b0;
                    timer     <= '0;
                    seen_busy <= 1'b0;
                    state     <= CMD_WAIT;
                end
                CMD_WAIT: begin
                    seen_busy <= seen_busy | spi_busy;
                    timer     <= timer + 1'b1;
                    if (complete) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            spi_go    <= 1'b1;
                            spi_datai <= rw_q ? '0 : wdata_q;
                            state     <= DATA_GO;
                        end
                    end else if (timer == TIMER_LAST) begin
                        // Abandon the transfer; the master is left to finish on its own.
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        spi_go    <= 1'b1;
                        spi_datai <= rw_q ? '0 : wdata_q;
                        state     <= DATA_GO;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DATA_GO: begin
                    spi_go    <= 1'b0;
                    timer     <= '0;
                    seen_busy <= 1'b0;
                    state     <= DATA_WAIT;
                end
                DATA_WAIT: begin
                    seen_busy <= seen_busy | spi_busy;
                    timer     <= timer + 1'b1;
                    if (complete) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= rw_q ? spi_datao : '0;
                        state     <= RESP;
                    end else if (timer == TIMER_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_reg_seq.md
# spi_reg_seq

Register-access sequencer sitting directly upstream of `spi_master`. It accepts single register read/write requests over a valid/ready interface and issues them as two back-to-back SPI words through the master: a command word `{rw, addr}` followed by a data word. It returns the read data, or an error on timeout, over a valid/ready response interface.

## Interface
- `DATA_WIDTH`, default 8: SPI word width; must match the attached `spi_master`.
- `GAP_CYCLES`, default 2: idle clk cycles inserted between the command word and the data word; 0 is allowed.
- `TIMEOUT`, default 1023: maximum cycles spent waiting for one word to complete; must be ≥ 2.
- `clk`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_rw`  in  1  1 = read, 0 = write.
- `req_addr`  in  DATA_WIDTH-1  register address.
- `req_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when high together with `rsp_valid`.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and for errors.
- `rsp_err`  out  1  1 = timeout occurred.
- `spi_go`  out  1  to master `go`.
- `spi_datai`  out  DATA_WIDTH  to master `datai`.
- `spi_datao`  in  DATA_WIDTH  from master `datao`.
- `spi_busy`  in  1  from master `busy`.
- `spi_done`  in  1  from master `done`.

## Operation
- States: IDLE, CMD_GO, CMD_WAIT, GAP, DATA_GO, DATA_WAIT, RESP.
- IDLE: `req_ready`=1. On accept, register rw/addr/wdata and go to CMD_GO. `req_ready`=0 in every other state.
- CMD_GO: `spi_go`=1 for exactly this cycle; `spi_datai`={rw, addr}. Then go to CMD_WAIT.
- *_WAIT:
  - On entry, clear `seen_busy` and the timer.
  - `seen_busy` sets when `spi_busy`=1.
  - Completion is `seen_busy` && `spi_busy`=0 && `spi_done`=1, sampled in this state. A stale `done` before the master goes busy is ignored.
  - The timer increments each cycle. If the timer equals TIMEOUT-1 and completion is false, go to RESP with `rsp_err`=1 and `rsp_rdata`=0. The second word is never issued, and the master is not aborted.
- CMD_WAIT completion: go to GAP if GAP_CYCLES>0, else to DATA_GO.
- GAP: hold for exactly GAP_CYCLES cycles, then go to DATA_GO.
- DATA_GO: `spi_go`=1 for one cycle; `spi_datai` = wdata for a write, 0 for a read. Then go to DATA_WAIT.
- DATA_WAIT completion: for a read, capture `spi_datao` into `rsp_rdata`; for a write, set `rsp_rdata`=0. Set `rsp_err`=0 and go to RESP.
- RESP: `rsp_valid`=1, with `rsp_rdata`/`rsp_err` held stable until `rsp_ready`=1, then return to IDLE.
- Timer width is $clog2(TIMEOUT); the GAP counter width is $clog2(GAP_CYCLES+1), minimum 1.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `spi_go`=0, `spi_datai`=0, timer/gap/`seen_busy`=0.
- Reset mid-operation: all reset values appear on the next edge and any in-flight request is dropped. The master is not reset by this block; the system resets both.
- Request accepted at edge n: `spi_go`=1 during cycle n+1.
- CMD completion sampled at cycle c: DATA_GO occurs at cycle c+1+GAP_CYCLES.
- DATA completion at cycle d: `rsp_valid`=1 from cycle d+1.
- Response handshake at cycle r: `req_ready`=1 at r+1. Minimum request-to-request spacing is one IDLE cycle.
- `spi_datai` is stable from its GO cycle through the end of the matching WAIT.
- All outputs are registered.

## Test plan
- Write, DATA_WIDTH=8, addr 0x12, wdata 0xA5, master model busy 20 cycles per word. Expect exactly two `spi_go` pulses with `spi_datai`=0x12 then 0xA5, and a response with `rsp_err`=0, `rsp_rdata`=0x00.
- Read addr 0x05, master returns 0x3C on the second word. Expect the command word 0x85, data word 0x00, and `rsp_rdata`=0x3C, `rsp_err`=0.
- Gap check: GAP_CYCLES=3, with CMD completion at cycle c. The second `spi_go` must occur at c+4. Repeat with GAP_CYCLES=0: expect c+1.
- Timeout: TIMEOUT=16, master never asserts busy, and `spi_done` is stuck at 1. Expect `rsp_valid` after 16 CMD_WAIT cycles with `rsp_err`=1, `rsp_rdata`=0, and no second `spi_go`.
- Backpressure: hold `rsp_ready`=0 for 10 cycles. Response fields stay stable, `req_ready` stays 0, and a queued request is accepted the cycle after the response handshake.
- Reset asserted during DATA_WAIT. Next cycle, all outputs are at reset values with `req_ready`=1; a following write completes normally.
